// File: rtl/ball_motion_sched_pkg.sv
// Shared definitions for the ball motion scheduler.
//   state_e     : update-pass FSM states
//   slot_t      : per-ball state (position, speed, direction)
//   slot_reset  : reset contents of a given slot index
//   *Default    : default screen geometry and ball radius
package ball_motion_sched_pkg;

  localparam int unsigned ScrWDefault   = 640;
  localparam int unsigned ScrHDefault   = 480;
  localparam int unsigned RadiusDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StCommit,
    StDone
  } state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] sx;
    logic [3:0] sy;
    logic       dx;  // 1 = moving towards larger x
    logic       dy;  // 1 = moving towards larger y
  } slot_t;

  // x = 64 + 128*i, y = 64 + 96*i built from shifts so no multiplier is implied.
  function automatic slot_t slot_reset(input int unsigned i);
    slot_t s;
    s.x  = 10'(64 + (i << 7));
    s.y  = 10'(64 + (i << 6) + (i << 5));
    s.sx = 4'(i + 1);
    s.sy = 4'd2;
    s.dx = 1'b1;
    s.dy = ~i[0];
    return s;
  endfunction

endpackage

// File: rtl/ball_motion_sched_axis_step.sv
// One axis of the shared motion datapath, purely combinational.
//   pos_i/speed_i/dir_i : current slot position, speed and direction
//   limit_i             : upper clamp bound (screen size - 1 - radius)
//   sum_o               : pos +/- speed, 11-bit signed, no wrap
//   sum_i               : previously registered sum to be clamped
//   pos_o/dir_o         : clamped position and possibly reflected direction
module ball_motion_sched_axis_step #(
  parameter int unsigned Radius = 16
) (
  input  logic [9:0]         pos_i,
  input  logic [3:0]         speed_i,
  input  logic               dir_i,
  input  logic [9:0]         limit_i,
  input  logic signed [10:0] sum_i,
  output logic signed [10:0] sum_o,
  output logic [9:0]         pos_o,
  output logic               dir_o
);

  logic signed [10:0] pos_s;
  logic signed [10:0] speed_s;

  always_comb begin
    pos_s   = $signed({1'b0, pos_i});
    speed_s = $signed({7'b0, speed_i});
    sum_o   = dir_i ? (pos_s + speed_s) : (pos_s - speed_s);
  end

  always_comb begin
    pos_o = sum_i[9:0];
    dir_o = dir_i;
    if (sum_i < $signed(11'(Radius))) begin
      pos_o = 10'(Radius);
      dir_o = 1'b1;
    end else if (sum_i > $signed({1'b0, limit_i})) begin
      pos_o = limit_i;
      dir_o = 1'b0;
    end
  end

endmodule

// File: rtl/ball_motion_sched.sv
// Per-frame position update for N_BALLS bouncing balls through one shared
// add/clamp datapath (one axis_step per axis), sequenced by a small FSM.
//   clk, rst_n     : pixel clock, synchronous active-low reset
//   frame_tick_i   : frame-start pulse, starts a pass when idle and not paused
//   pause_i        : suppresses pass starts
//   rd_idx_i       : slot select for the combinational read port
//   rd_x_o/rd_y_o  : centre of the selected slot
//   busy_o         : pass in progress
//   done_o         : one-cycle pulse at end of pass
//   overrun_o      : sticky, frame_tick seen while busy
module ball_motion_sched
  import ball_motion_sched_pkg::*;
#(
  parameter int unsigned N_BALLS = 4,
  parameter int unsigned SCR_W   = ScrWDefault,
  parameter int unsigned SCR_H   = ScrHDefault,
  parameter int unsigned RADIUS  = RadiusDefault
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick_i,
  input  logic                       pause_i,
  input  logic [$clog2(N_BALLS)-1:0] rd_idx_i,
  output logic [9:0]                 rd_x_o,
  output logic [9:0]                 rd_y_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overrun_o
);

  localparam int unsigned    IdxW    = $clog2(N_BALLS);
  localparam logic [9:0]     XMax    = 10'(SCR_W - 1 - RADIUS);
  localparam logic [9:0]     YMax    = 10'(SCR_H - 1 - RADIUS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_BALLS - 1);

  state_e             state_q;
  logic [IdxW-1:0]    idx_q;
  logic               busy_q;
  logic               done_q;
  logic               overrun_q;
  slot_t              slot_q [N_BALLS];
  logic signed [10:0] nx_q;
  logic signed [10:0] ny_q;

  slot_t              cur;
  logic signed [10:0] sum_x;
  logic signed [10:0] sum_y;
  logic [9:0]         new_x;
  logic [9:0]         new_y;
  logic               new_dx;
  logic               new_dy;

  assign cur = slot_q[idx_q];

  ball_motion_sched_axis_step #(
    .Radius(RADIUS)
  ) u_step_x (
    .pos_i  (cur.x),
    .speed_i(cur.sx),
    .dir_i  (cur.dx),
    .limit_i(XMax),
    .sum_i  (nx_q),
    .sum_o  (sum_x),
    .pos_o  (new_x),
    .dir_o  (new_dx)
  );

  ball_motion_sched_axis_step #(
    .Radius(RADIUS)
  ) u_step_y (
    .pos_i  (cur.y),
    .speed_i(cur.sy),
    .dir_i  (cur.dy),
    .limit_i(YMax),
    .sum_i  (ny_q),
    .sum_o  (sum_y),
    .pos_o  (new_y),
    .dir_o  (new_dy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      nx_q      <= '0;
      ny_q      <= '0;
      for (int unsigned i = 0; i < N_BALLS; i++) begin
        slot_q[i] <= slot_reset(i);
      end
    end else begin
      if (frame_tick_i && busy_q) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (frame_tick_i && !pause_i) begin
            state_q <= StCalc;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StCalc: begin
          nx_q    <= sum_x;
          ny_q    <= sum_y;
          state_q <= StCommit;
        end
        StCommit: begin
          // Both axes commit together; the slot is only visible on the
          // read port as updated from this edge onwards.
          slot_q[idx_q].x  <= new_x;
          slot_q[idx_q].dx <= new_dx;
          slot_q[idx_q].y  <= new_y;
          slot_q[idx_q].dy <= new_dy;
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StCalc;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_x_o    = slot_q[rd_idx_i].x;
  assign rd_y_o    = slot_q[rd_idx_i].y;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_ball_motion_sched.sv
module tb_ball_motion_sched;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       pause;
  logic [1:0] rd_idx;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic       busy;
  logic       done;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  localparam int RstX [4]  = '{64, 192, 320, 448};
  localparam int RstY [4]  = '{64, 160, 256, 352};
  localparam int OneX [4]  = '{65, 194, 323, 452};
  localparam int OneY [4]  = '{66, 158, 258, 350};

  ball_motion_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick_i(frame_tick),
    .pause_i     (pause),
    .rd_idx_i    (rd_idx),
    .rd_x_o      (rd_x),
    .rd_y_o      (rd_y),
    .busy_o      (busy),
    .done_o      (done),
    .overrun_o   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    pause      = 1'b0;
    rd_idx     = 2'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Starts a pass and waits (bounded) for its done pulse, then one more cycle.
  task automatic run_pass();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 0; k < 20 && !done; k++) step();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL pass_timeout: done=%0b required 1", done);
    end
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b required 0", done); end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL reset_overrun: got %0b required 0", overrun);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_x !== 10'(RstX[i]) || rd_y !== 10'(RstY[i])) begin
        errors++;
        $display("FAIL reset_pos slot %0d: got (%0d,%0d) required (%0d,%0d)",
                 i, rd_x, rd_y, RstX[i], RstY[i]);
      end
    end
  endtask

  task automatic test_single_pass();
    do_reset();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL pass_busy cycle %0d: got %0b required 1", c, busy);
      end
      checks++;
      if (done !== (c == 9)) begin
        errors++; $display("FAIL pass_done cycle %0d: got %0b required %0b", c, done, c == 9);
      end
      if (c == 2 || c == 3) begin
        rd_idx = 2'd0;
        #1;
        checks++;
        if (rd_x !== ((c == 2) ? 10'd64 : 10'd65)) begin
          errors++;
          $display("FAIL pre_update cycle %0d: got x=%0d required %0d", c, rd_x,
                   (c == 2) ? 64 : 65);
        end
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL pass_end: got busy=%0b done=%0b required 0 0", busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_x !== 10'(OneX[i]) || rd_y !== 10'(OneY[i])) begin
        errors++;
        $display("FAIL pass_pos slot %0d: got (%0d,%0d) required (%0d,%0d)",
                 i, rd_x, rd_y, OneX[i], OneY[i]);
      end
    end
  endtask

  task automatic test_overrun();
    int dones;
    do_reset();
    dones = 0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_early: got %0b required 0", overrun);
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL overrun_dones: got %0d required 1", dones); end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: got %0b required 1", overrun);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_x !== 10'(OneX[i]) || rd_y !== 10'(OneY[i])) begin
        errors++;
        $display("FAIL overrun_pos slot %0d: got (%0d,%0d) required (%0d,%0d)",
                 i, rd_x, rd_y, OneX[i], OneY[i]);
      end
    end
  endtask

  task automatic test_pause();
    int busy_cycles;
    int dones;
    do_reset();
    pause = 1'b1;
    for (int t = 0; t < 5; t++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL pause_busy tick %0d: got %0b required 0", t, busy);
      end
      step();
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL pause_overrun: got %0b required 0", overrun);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_x !== 10'(RstX[i]) || rd_y !== 10'(RstY[i])) begin
        errors++;
        $display("FAIL pause_pos slot %0d: got (%0d,%0d) required (%0d,%0d)",
                 i, rd_x, rd_y, RstX[i], RstY[i]);
      end
    end
    pause = 1'b0;
    busy_cycles = 0;
    dones = 0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) dones++;
      step();
    end
    checks++;
    if (busy_cycles != 9) begin
      errors++; $display("FAIL unpause_busy_cycles: got %0d required 9", busy_cycles);
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL unpause_dones: got %0d required 1", dones); end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_x !== 10'(OneX[i]) || rd_y !== 10'(OneY[i])) begin
        errors++;
        $display("FAIL unpause_pos slot %0d: got (%0d,%0d) required (%0d,%0d)",
                 i, rd_x, rd_y, OneX[i], OneY[i]);
      end
    end
  endtask

  // Slot 3 x: 448 + 4p until 624 would exceed 623 at p=44, then back down.
  // Slot 1 y: 160 - 2p reaches 16 at p=72, would be 14 at p=73, clamps, then rises.
  task automatic test_bounce();
    int exp_x3;
    int exp_y1;
    do_reset();
    for (int p = 1; p <= 74; p++) begin
      run_pass();
      if (p == 43 || p == 44 || p == 45 || p == 46) begin
        exp_x3 = (p == 43) ? 620 : (p == 44) ? 623 : (p == 45) ? 619 : 615;
        rd_idx = 2'd3;
        #1;
        checks++;
        if (rd_x !== 10'(exp_x3)) begin
          errors++; $display("FAIL bounce_hi pass %0d: got x=%0d required %0d", p, rd_x, exp_x3);
        end
      end
      if (p == 72 || p == 73 || p == 74) begin
        exp_y1 = (p == 72) ? 16 : (p == 73) ? 16 : 18;
        rd_idx = 2'd1;
        #1;
        checks++;
        if (rd_y !== 10'(exp_y1)) begin
          errors++; $display("FAIL bounce_lo pass %0d: got y=%0d required %0d", p, rd_y, exp_y1);
        end
      end
    end
  endtask

  task automatic test_reset_midpass();
    int dones;
    do_reset();
    dones = 0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    frame_tick = 1'b1;  // cycle 3: sets overrun
    step();
    frame_tick = 1'b0;
    step();
    step();             // cycle 6: COMMIT of slot 2
    rd_idx = 2'd0;
    #1;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1 || rd_x !== 10'd65) begin
      errors++;
      $display("FAIL midpass_pre: got overrun=%0b busy=%0b x0=%0d required 1 1 65",
               overrun, busy, rd_x);
    end
    rst_n = 1'b0;
    step();
    if (done === 1'b1) dones++;
    step();
    if (done === 1'b1) dones++;
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midpass_done: got %0d required 0", dones); end
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midpass_flags: got overrun=%0b busy=%0b required 0 0", overrun, busy);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_x !== 10'(RstX[i]) || rd_y !== 10'(RstY[i])) begin
        errors++;
        $display("FAIL midpass_pos slot %0d: got (%0d,%0d) required (%0d,%0d)",
                 i, rd_x, rd_y, RstX[i], RstY[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_overrun();
    test_pause();
    test_bounce();
    test_reset_midpass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
